// File: rtl/rng_collector.sv
// rng_collector: gathers 4-bit PRNG nibbles into 16-bit words, hands them to a
// consumer through a one-deep output register, and runs a repetition-count
// health test that flags a source producing the same nibble too many times.
module rng_collector #(
   parameter int REP_LIMIT = 8
) (
   input  logic        clk,
   input  logic        res,
   input  logic [3:0]  din,
   input  logic        din_done,
   input  logic        rd,
   output logic [15:0] word,
   output logic        word_valid,
   output logic        overrun,
   output logic        stuck
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   localparam logic [3:0] LIMIT = 4'(REP_LIMIT);

   out_state_t  state;
   logic [1:0]  nib_idx;
   logic [15:0] asm_reg;
   logic [3:0]  last_nib;
   logic [3:0]  run_cnt;
   logic [3:0]  run_cnt_next;
   logic        complete;
   logic [15:0] new_word;

   // The fourth nibble finishes a word; it goes straight into the top bits
   // so the word can be loaded in the same cycle it arrives.
   assign complete = din_done && (nib_idx == 2'd3);
   assign new_word = {din, asm_reg[11:0]};

   // Next run length: a zero counter means no nibble seen since reset, so
   // the first nibble always starts a run of one; repeats saturate at 15.
   always_comb begin
      run_cnt_next = 4'd1;
      if (run_cnt != 4'd0 && din == last_nib) begin
         run_cnt_next = (run_cnt == 4'd15) ? 4'd15 : run_cnt + 4'd1;
      end
   end

   // Nibble assembly and repetition health test; both keep running no matter
   // what the output side is doing.
   always_ff @(posedge clk) begin
      if (res) begin
         nib_idx  <= 2'd0;
         asm_reg  <= 16'h0000;
         last_nib <= 4'h0;
         run_cnt  <= 4'd0;
         stuck    <= 1'b0;
      end else if (din_done) begin
         asm_reg[4*nib_idx +: 4] <= din;
         nib_idx  <= nib_idx + 2'd1;
         last_nib <= din;
         run_cnt  <= run_cnt_next;
         if (run_cnt_next == LIMIT) begin
            stuck <= 1'b1;
         end
      end
   end

   // Output handshake: a completed word is loaded when the register is empty
   // or being emptied this cycle, otherwise it is dropped and overrun is set.
   always_ff @(posedge clk) begin
      if (res) begin
         state      <= EMPTY;
         word       <= 16'h0000;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (complete) begin
                  word       <= new_word;
                  word_valid <= 1'b1;
                  state      <= FULL;
               end
            end
            FULL: begin
               if (complete) begin
                  if (rd) begin
                     word <= new_word;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (rd) begin
                  word_valid <= 1'b0;
                  state      <= EMPTY;
               end
            end
            default: begin
               state      <= EMPTY;
               word_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rng_collector.sv
// Directed self-checking bench for rng_collector.
module tb_rng_collector;

   logic        clk;
   logic        res;
   logic [3:0]  din;
   logic        din_done;
   logic        rd;
   logic [15:0] word;
   logic        word_valid;
   logic        overrun;
   logic        stuck;

   int passed = 0;
   int total  = 0;

   rng_collector #(.REP_LIMIT(8)) dut (
      .clk        (clk),
      .res        (res),
      .din        (din),
      .din_done   (din_done),
      .rd         (rd),
      .word       (word),
      .word_valid (word_valid),
      .overrun    (overrun),
      .stuck      (stuck)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then settle just after the rising edge.
   task automatic tick(input logic r, input logic dd, input logic [3:0] d, input logic rdy);
      res      = r;
      din_done = dd;
      din      = d;
      rd       = rdy;
      @(posedge clk);
      #1;
      res      = 1'b0;
      din_done = 1'b0;
      rd       = 1'b0;
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 4'h0, 1'b0);
      tick(1'b1, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (word !== 16'h0000) $display("[TB] FAIL reset_word got %h exp 0000", word); else passed++;
      total++; if (word_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b exp 0", word_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun got %b exp 0", overrun); else passed++;
      total++; if (stuck !== 1'b0) $display("[TB] FAIL reset_stuck got %b exp 0", stuck); else passed++;
   endtask

   task automatic test_assemble();
      do_reset();
      tick(1'b0, 1'b1, 4'h1, 1'b0);
      tick(1'b0, 1'b1, 4'h2, 1'b0);
      tick(1'b0, 1'b1, 4'h3, 1'b0);
      total++; if (word_valid !== 1'b0) $display("[TB] FAIL asm_early_valid got %b exp 0", word_valid); else passed++;
      tick(1'b0, 1'b1, 4'h4, 1'b0);
      total++; if (word_valid !== 1'b1) $display("[TB] FAIL asm_valid got %b exp 1", word_valid); else passed++;
      total++; if (word !== 16'h4321) $display("[TB] FAIL asm_word got %h exp 4321", word); else passed++;
      total++; if (stuck !== 1'b0) $display("[TB] FAIL asm_stuck got %b exp 0", stuck); else passed++;
      total++; if (overrun !== 1'b0) $display("[TB] FAIL asm_overrun got %b exp 0", overrun); else passed++;
   endtask

   task automatic test_transfer();
      tick(1'b0, 1'b0, 4'h0, 1'b0);
      total++; if (word !== 16'h4321 || word_valid !== 1'b1) $display("[TB] FAIL hold got %h/%b exp 4321/1", word, word_valid); else passed++;
      tick(1'b0, 1'b0, 4'h0, 1'b1);
      total++; if (word_valid !== 1'b0) $display("[TB] FAIL xfer_valid got %b exp 0", word_valid); else passed++;
      tick(1'b0, 1'b1, 4'h5, 1'b0);
      tick(1'b0, 1'b1, 4'h6, 1'b0);
      tick(1'b0, 1'b1, 4'h7, 1'b0);
      tick(1'b0, 1'b1, 4'h8, 1'b0);
      total++; if (word !== 16'h8765 || word_valid !== 1'b1) $display("[TB] FAIL xfer_word2 got %h/%b exp 8765/1", word, word_valid); else passed++;
   endtask

   task automatic test_overrun();
      do_reset();
      tick(1'b0, 1'b1, 4'h1, 1'b0);
      tick(1'b0, 1'b1, 4'h2, 1'b0);
      tick(1'b0, 1'b1, 4'h3, 1'b0);
      tick(1'b0, 1'b1, 4'h4, 1'b0);
      tick(1'b0, 1'b1, 4'h9, 1'b0);
      tick(1'b0, 1'b1, 4'hA, 1'b0);
      tick(1'b0, 1'b1, 4'hB, 1'b0);
      total++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_early got %b exp 0", overrun); else passed++;
      tick(1'b0, 1'b1, 4'hC, 1'b0);
      total++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag got %b exp 1", overrun); else passed++;
      total++; if (word !== 16'h4321 || word_valid !== 1'b1) $display("[TB] FAIL ovr_word got %h/%b exp 4321/1", word, word_valid); else passed++;
      tick(1'b0, 1'b0, 4'h0, 1'b1);
      total++; if (word_valid !== 1'b0) $display("[TB] FAIL ovr_xfer_valid got %b exp 0", word_valid); else passed++;
      total++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_sticky got %b exp 1", overrun); else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      tick(1'b0, 1'b1, 4'h1, 1'b0);
      tick(1'b0, 1'b1, 4'h2, 1'b0);
      tick(1'b0, 1'b1, 4'h3, 1'b0);
      tick(1'b0, 1'b1, 4'h4, 1'b0);
      tick(1'b0, 1'b1, 4'hD, 1'b0);
      tick(1'b0, 1'b1, 4'hE, 1'b0);
      tick(1'b0, 1'b1, 4'hF, 1'b0);
      total++; if (word !== 16'h4321) $display("[TB] FAIL b2b_hold got %h exp 4321", word); else passed++;
      tick(1'b0, 1'b1, 4'h0, 1'b1);
      total++; if (word !== 16'h0FED) $display("[TB] FAIL b2b_word got %h exp 0fed", word); else passed++;
      total++; if (word_valid !== 1'b1) $display("[TB] FAIL b2b_valid got %b exp 1", word_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("[TB] FAIL b2b_overrun got %b exp 0", overrun); else passed++;
      total++; if (stuck !== 1'b0) $display("[TB] FAIL b2b_stuck got %b exp 0", stuck); else passed++;
   endtask

   task automatic test_stuck();
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         tick(1'b0, 1'b1, 4'hA, 1'b1);
         if (i == 4) begin
            total++; if (word !== 16'hAAAA || word_valid !== 1'b1) $display("[TB] FAIL stuck_word1 got %h/%b exp aaaa/1", word, word_valid); else passed++;
         end
      end
      total++; if (stuck !== 1'b0) $display("[TB] FAIL stuck_after7 got %b exp 0", stuck); else passed++;
      tick(1'b0, 1'b1, 4'hA, 1'b1);
      total++; if (stuck !== 1'b1) $display("[TB] FAIL stuck_after8 got %b exp 1", stuck); else passed++;
      total++; if (word !== 16'hAAAA || word_valid !== 1'b1) $display("[TB] FAIL stuck_word2 got %h/%b exp aaaa/1", word, word_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("[TB] FAIL stuck_overrun got %b exp 0", overrun); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(1'b0, 1'b1, 4'h1, 1'b0);
      tick(1'b0, 1'b1, 4'h2, 1'b0);
      tick(1'b1, 1'b1, 4'h3, 1'b0);
      tick(1'b0, 1'b1, 4'h5, 1'b0);
      tick(1'b0, 1'b1, 4'h6, 1'b0);
      tick(1'b0, 1'b1, 4'h7, 1'b0);
      total++; if (word_valid !== 1'b0) $display("[TB] FAIL mid_early_valid got %b exp 0", word_valid); else passed++;
      tick(1'b0, 1'b1, 4'h8, 1'b0);
      total++; if (word !== 16'h8765 || word_valid !== 1'b1) $display("[TB] FAIL mid_word got %h/%b exp 8765/1", word, word_valid); else passed++;
      total++; if (stuck !== 1'b0 || overrun !== 1'b0) $display("[TB] FAIL mid_flags got %b%b exp 00", stuck, overrun); else passed++;
      tick(1'b1, 1'b0, 4'h0, 1'b0);
      total++; if (word_valid !== 1'b0 || word !== 16'h0000) $display("[TB] FAIL full_reset got %h/%b exp 0000/0", word, word_valid); else passed++;
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      res      = 1'b1;
      din      = 4'h0;
      din_done = 1'b0;
      rd       = 1'b0;
      test_reset();
      test_assemble();
      test_transfer();
      test_overrun();
      test_back_to_back();
      test_stuck();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rng_collector.md
RNG_COLLECTOR -- requirements
Module: rng_collector

Interface
REQ-001 SHALL have parameter REP_LIMIT, default 8, the number of consecutive identical nibbles that flags a stuck source; legal range 2..15.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port din  input  4  nibble from the PRNG source.
REQ-005 SHALL have port din_done  input  1  one-cycle strobe; din is valid in the same cycle.
REQ-006 SHALL have port rd  input  1  consumer ready; a transfer occurs when word_valid and rd are both 1.
REQ-007 SHALL have port word  output  16  assembled random word.
REQ-008 SHALL have port word_valid  output  1  word holds an untransferred value.
REQ-009 SHALL have port overrun  output  1  sticky; a completed word was discarded.
REQ-010 SHALL have port stuck  output  1  sticky; the repetition-count health test failed.

Function
REQ-011 SHALL sample din only in cycles where din_done=1, and SHALL ignore din otherwise.
REQ-012 SHALL keep a 2-bit nibble index (0..3) and a 16-bit assembly register.
REQ-013 SHALL write an accepted nibble with index k to assembly bits [4k+3:4k], then increment the index, wrapping 3->0.
REQ-014 SHALL treat the nibble with index 3 as completing a word (assembly bits [11:0] plus the new din in [15:12]).
REQ-015 SHALL run an output state machine with states EMPTY (word_valid=0) and FULL (word_valid=1).
REQ-016 In EMPTY, on word completion: SHALL load word and go to FULL; word_valid SHALL rise in the cycle after the 4th din_done, giving 1-cycle latency.
REQ-017 In FULL with rd=1 and no completion: SHALL transfer and go to EMPTY; word_valid SHALL be 0 the next cycle.
REQ-018 In FULL with rd=1 and a completion in the same cycle: SHALL load the new word and stay FULL, with no overrun.
REQ-019 In FULL with rd=0 and a completion: SHALL discard the new word, keep word unchanged, and set overrun=1.
REQ-020 SHALL continue nibble assembly regardless of the output state.
REQ-021 SHALL hold word stable while word_valid=1 and no load occurs.
REQ-022 SHALL keep word at its last value after a transfer; word is don't-care when word_valid=0.
REQ-023 Repetition test: SHALL keep the last accepted nibble and a 4-bit run counter.
  - Run counter = 1 on the first nibble after reset.
  - On each accepted nibble: increment if equal to the last nibble, else reload to 1.
  - Counter SHALL saturate at 15.
REQ-024 SHALL set stuck=1 in the cycle after the accepted nibble that brings the run counter to REP_LIMIT.
REQ-025 stuck SHALL NOT block assembly or output.
REQ-026 overrun and stuck SHALL clear only on reset.
REQ-027 din_done in consecutive cycles SHALL be accepted every cycle, with no throughput loss.

Reset
REQ-028 res SHALL take priority over all other inputs; a din_done in a reset cycle SHALL be discarded.
REQ-029 On reset SHALL set the following, from the next cycle:
  - word=16'h0000, word_valid=0, overrun=0, stuck=0
  - nibble index=0, assembly register=0, run counter=0
  - state=EMPTY
REQ-030 Reset during assembly SHALL discard the partial word; the next accepted nibble SHALL go to bits [3:0].
REQ-031 Reset while FULL SHALL drop the held word.

Verification
REQ-032 Nibbles 1,2,3,4 on four strobes, rd=0 -> word=16'h4321 and word_valid=1 one cycle after the 4th strobe; stuck=0, overrun=0.
REQ-033 Held 16'h4321, then rd=1 for one cycle -> word_valid=0 the next cycle; nibbles 5,6,7,8 -> word=16'h8765.
REQ-034 FULL with rd=0, four more strobes (9,A,B,C) -> overrun=1 and word still 16'h4321; then rd=1 -> word_valid=0, overrun stays 1.
REQ-035 FULL, rd=1 in the same cycle as a 4th strobe (nibbles D,E,F,0) -> word=16'h0FED, word_valid stays 1, overrun=0.
REQ-036 Eight consecutive strobes of 4'hA with REP_LIMIT=8 -> stuck=1 one cycle after the 8th strobe (not after the 7th); word=16'hAAAA completes normally.
REQ-037 Strobes 1,2, then res=1 together with a strobe of 3, then strobes 5,6,7,8 -> word=16'h8765; stuck=0, overrun=0.
